reg_access_ctrl: RTL and testbench
==================================

Name: reg_access_ctrl

Overview:
- Parametrised register-access slave front-end that sits between the host register bus and a block's internal register decode.
- Registers the incoming bus request and drives a decode enable and address into the block.
- Completes accesses either immediately from internal decode or deferred through one of NUM_CH memory-style channels.
- Adds per-request timeout, abort on early deselect, and error status capture.

Parameters:
DATA_W, 32, register data width
ADDR_W, 32, byte-address width; the bus carries word address bits [ADDR_W-1:2]
NUM_CH, 2, number of deferred-access channels (1..8)
TIMEOUT, 1023, maximum cycles spent in REQ before forced completion (1..65535)
CNT_W, 16, width of the saturating error counter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
registerSelect  input  1  bus access request, held until ack seen
registerRead  input  1  1=read, 0=write
registerAddress  input  ADDR_W-2  word address
registerWriteData  input  DATA_W  write data
readDataInternal  input  DATA_W  read data from internal decode
decodeInternal  input  1  internal decode hit for decodeAddress
memReqTrigger  input  NUM_CH  per-channel request for deferred completion, valid while decodeEn=1
memAckTrigger  input  NUM_CH  per-channel completion
registerReadData  output  DATA_W  registered read data
registerAck  output  1  single-cycle completion pulse
registerError  output  1  single-cycle error, coincident with ack
decodeEn  output  1  decode qualifier to internal logic
decodeAddress  output  ADDR_W  {registered word address, 2'b00}
registerReadS  output  1  registered read flag
registerWriteDataS  output  DATA_W  registered write data
memChannel  output  NUM_CH  one-hot channel owning the current deferred access, 0 otherwise
memAbort  output  1  single-cycle pulse when a deferred access is abandoned
timeoutFlag  output  1  sticky; set on timeout, cleared by next successful ack
errorCount  output  CNT_W  saturating count of ack-with-error events
lastErrAddr  output  ADDR_W  decodeAddress of the most recent errored access

Behaviour:
- Reset: all outputs and internal flops 0; state IDLE.
- Input stage: select, read, address and write data registered every cycle (1-cycle latency); all decode uses the registered copies.
- decodeEn = 1 in IDLE while selS=1, and in REQ and ACK; 0 in WAIT.
- IDLE:
  - If selS=1 and no memReqTrigger bit is set: next cycle ack=1, error=!decodeInternal, readData<=readDataInternal; go to WAIT.
  - If selS=1 and any memReqTrigger bit is set: latch the lowest-index set bit into memChannel, clear the timeout counter, go to REQ.
- REQ:
  - The counter increments each cycle.
  - memAckTrigger[ch] of the latched channel → ACK. Acks on other channels are ignored.
  - selS=0 → pulse memAbort for 1 cycle, clear memChannel, return to IDLE. No ack. Abort wins over a same-cycle ack.
  - Counter == TIMEOUT-1 without ack/abort → set timeoutFlag, go to ACK with a forced error.
- ACK (one cycle): ack=1; readData<=readDataInternal, or 0 if timed out; error=!decodeInternal | timed-out; clear memChannel; go to WAIT.
- WAIT: hold until selS=0, then IDLE. A new select needs at least one deasserted registered cycle.
- Write accesses follow the same flow. readData still updates from readDataInternal on write completion.
- Error bookkeeping:
  - Each ack with error=1 increments errorCount, saturating at all-ones, and captures lastErrAddr.
  - A non-error ack clears timeoutFlag.
- Reset mid-access returns to IDLE immediately, with no ack and no abort pulse.

Test Plan:
- Internal hit: select addr 0x10, read, decodeInternal=1, readDataInternal=0xA5A5_0001 → ack 2 cycles after select rises, data 0xA5A5_0001, error=0, decodeAddress=0x10.
- Internal miss: select addr 0x7FC, decodeInternal=0 → ack+error same cycle, errorCount=1, lastErrAddr=0x7FC.
- Deferred: memReqTrigger=2'b11 → memChannel=2'b01. memAckTrigger=2'b10 ignored; memAckTrigger=2'b01 after 5 cycles → ack next cycle with readDataInternal=0x1234, memChannel cleared.
- Timeout: TIMEOUT=8, memReqTrigger=01, no ack → ack+error 9 cycles after REQ entry, data 0, timeoutFlag=1; next clean access clears it.
- Abort: deselect in REQ with same-cycle memAckTrigger → memAbort 1-cycle pulse, no ack, state IDLE.
- Saturation/reset: CNT_W=2, 5 errored accesses → errorCount=3. Assert reset during REQ → all outputs 0, next access completes normally.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// Register-access slave front-end.
// Registers the host bus request, drives decode enable/address into the block,
// and completes each access either directly from internal decode or after a
// deferred handshake on one of NUM_CH memory-style channels. Adds a per-request
// timeout, abort on early deselect, and error status capture.
module reg_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_CH  = 2,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              registerSelect,
    input  logic              registerRead,
    input  logic [ADDR_W-3:0] registerAddress,
    input  logic [DATA_W-1:0] registerWriteData,
    input  logic [DATA_W-1:0] readDataInternal,
    input  logic              decodeInternal,
    input  logic [NUM_CH-1:0] memReqTrigger,
    input  logic [NUM_CH-1:0] memAckTrigger,
    output logic [DATA_W-1:0] registerReadData,
    output logic              registerAck,
    output logic              registerError,
    output logic              decodeEn,
    output logic [ADDR_W-1:0] decodeAddress,
    output logic              registerReadS,
    output logic [DATA_W-1:0] registerWriteDataS,
    output logic [NUM_CH-1:0] memChannel,
    output logic              memAbort,
    output logic              timeoutFlag,
    output logic [CNT_W-1:0]  errorCount,
    output logic [ADDR_W-1:0] lastErrAddr
);

    // Timeout counter wide enough for the largest supported TIMEOUT.
    localparam int TO_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    // Registered bus copies; all decode works from these.
    logic              sel_s;
    logic [ADDR_W-3:0] addr_s;

    // Deferred-access bookkeeping.
    logic [TO_W-1:0]   to_cnt;
    logic              timed_out;
    logic              any_req;
    logic [NUM_CH-1:0] req_pick;
    logic              ch_ack;
    logic              to_expired;

    // Per-cycle decisions produced by the output decoder.
    logic ack_nxt;
    logic err_nxt;
    logic abort_nxt;
    logic to_set;
    logic ch_load;
    logic ch_clear;
    logic rdata_zero;

    // Input stage: capture the bus request every cycle.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // pre-edge values regardless of statement or process order.
        if (!reset) begin
            sel_s              <= 1'b0;
            registerReadS      <= 1'b0;
            addr_s             <= '0;
            registerWriteDataS <= '0;
        end else begin
            sel_s              <= registerSelect;
            registerReadS      <= registerRead;
            addr_s             <= registerAddress;
            registerWriteDataS <= registerWriteData;
        end
    end

    assign decodeAddress = {addr_s, 2'b00};
    assign any_req       = |memReqTrigger;
    assign ch_ack        = |(memAckTrigger & memChannel);
    assign to_expired    = (to_cnt == TO_W'(TIMEOUT - 1));

    // Pick the lowest-index channel requesting deferred completion.
    always_comb begin
        req_pick = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (memReqTrigger[i] && (req_pick == '0)) begin
                req_pick[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort on deselect outranks a channel ack or timeout.
    always_comb begin
        // NOTE: default every combinational output first so no path through
        // the case leaves it unassigned and infers a latch.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sel_s) begin
                    state_nxt = any_req ? ST_REQ : ST_WAIT;
                end
            end
            ST_REQ: begin
                if (!sel_s) begin
                    state_nxt = ST_IDLE;
                end else if (ch_ack || to_expired) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!sel_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: decode enable plus the values loaded at the next edge.
    always_comb begin
        decodeEn   = 1'b0;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        abort_nxt  = 1'b0;
        to_set     = 1'b0;
        ch_load    = 1'b0;
        ch_clear   = 1'b0;
        rdata_zero = 1'b0;
        case (state)
            ST_IDLE: begin
                decodeEn = sel_s;
                if (sel_s && !any_req) begin
                    ack_nxt = 1'b1;
                    err_nxt = !decodeInternal;
                end
                ch_load = sel_s && any_req;
            end
            ST_REQ: begin
                decodeEn = 1'b1;
                if (!sel_s) begin
                    abort_nxt = 1'b1;
                    ch_clear  = 1'b1;
                end else if (!ch_ack && to_expired) begin
                    to_set = 1'b1;
                end
            end
            ST_ACK: begin
                decodeEn   = 1'b1;
                ack_nxt    = 1'b1;
                err_nxt    = !decodeInternal || timed_out;
                rdata_zero = timed_out;
                ch_clear   = 1'b1;
            end
            default: begin
                decodeEn = 1'b0;
            end
        endcase
    end

    // Deferred-access state: channel ownership, timeout counter and flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memChannel <= '0;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
        end else begin
            if (ch_load) begin
                memChannel <= req_pick;
            end else if (ch_clear) begin
                memChannel <= '0;
            end

            if (ch_load) begin
                to_cnt <= '0;
            end else if (state == ST_REQ) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (to_set) begin
                timed_out <= 1'b1;
            end else if (ack_nxt) begin
                timed_out <= 1'b0;
            end
        end
    end

    // Completion outputs: ack/error/abort pulses and captured read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            registerAck      <= 1'b0;
            registerError    <= 1'b0;
            memAbort         <= 1'b0;
            registerReadData <= '0;
        end else begin
            registerAck   <= ack_nxt;
            registerError <= ack_nxt && err_nxt;
            memAbort      <= abort_nxt;
            if (ack_nxt) begin
                registerReadData <= rdata_zero ? '0 : readDataInternal;
            end
        end
    end

    // Error status: saturating error count, last errored address, timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            errorCount  <= '0;
            lastErrAddr <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            if (ack_nxt && err_nxt) begin
                if (errorCount != '1) begin
                    errorCount <= errorCount + CNT_W'(1);
                end
                lastErrAddr <= decodeAddress;
            end

            if (to_set) begin
                timeoutFlag <= 1'b1;
            end else if (ack_nxt && !err_nxt) begin
                timeoutFlag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Testbench for reg_access_ctrl: directed accesses, expected completions queued
// by the stimulus and compared by an independent monitor on the falling edge.
module tb_reg_access_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int NUM_CH  = 2;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              registerSelect;
    logic              registerRead;
    logic [ADDR_W-3:0] registerAddress;
    logic [DATA_W-1:0] registerWriteData;
    logic [DATA_W-1:0] readDataInternal;
    logic              decodeInternal;
    logic [NUM_CH-1:0] memReqTrigger;
    logic [NUM_CH-1:0] memAckTrigger;
    logic [DATA_W-1:0] registerReadData;
    logic              registerAck;
    logic              registerError;
    logic              decodeEn;
    logic [ADDR_W-1:0] decodeAddress;
    logic              registerReadS;
    logic [DATA_W-1:0] registerWriteDataS;
    logic [NUM_CH-1:0] memChannel;
    logic              memAbort;
    logic              timeoutFlag;
    logic [CNT_W-1:0]  errorCount;
    logic [ADDR_W-1:0] lastErrAddr;

    reg_access_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .registerSelect    (registerSelect),
        .registerRead      (registerRead),
        .registerAddress   (registerAddress),
        .registerWriteData (registerWriteData),
        .readDataInternal  (readDataInternal),
        .decodeInternal    (decodeInternal),
        .memReqTrigger     (memReqTrigger),
        .memAckTrigger     (memAckTrigger),
        .registerReadData  (registerReadData),
        .registerAck       (registerAck),
        .registerError     (registerError),
        .decodeEn          (decodeEn),
        .decodeAddress     (decodeAddress),
        .registerReadS     (registerReadS),
        .registerWriteDataS(registerWriteDataS),
        .memChannel        (memChannel),
        .memAbort          (memAbort),
        .timeoutFlag       (timeoutFlag),
        .errorCount        (errorCount),
        .lastErrAddr       (lastErrAddr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             is_abort;
        logic [31:0]      data;
        logic             err;
        logic [31:0]      addr;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      last;
        logic             tflag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_ack(input logic [31:0] data, input logic err, input logic [31:0] addr,
                                    input logic [CNT_W-1:0] cnt, input logic [31:0] last,
                                    input logic tflag);
        exp_t e;
        e          = '0;
        e.data     = data;
        e.err      = err;
        e.addr     = addr;
        e.cnt      = cnt;
        e.last     = last;
        e.tflag    = tflag;
        return e;
    endfunction

    function automatic exp_t mk_abort();
        exp_t e;
        e          = '0;
        e.is_abort = 1'b1;
        return e;
    endfunction

    // Monitor: every ack or abort pulse must match the oldest queued expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (registerError && !registerAck) begin
                check("error_without_ack", 1, 0);
            end
            if (registerAck || memAbort) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {registerAck, memAbort}, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind_abort", memAbort, e.is_abort);
                    if (e.is_abort) begin
                        check("abort_without_ack", registerAck, 0);
                    end else begin
                        check("ack_data", registerReadData, e.data);
                        check("ack_error", registerError, e.err);
                        check("ack_decode_addr", decodeAddress, e.addr);
                        check("ack_error_count", errorCount, e.cnt);
                        check("ack_last_err_addr", lastErrAddr, e.last);
                        check("ack_timeout_flag", timeoutFlag, e.tflag);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive_bus(input logic sel, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata);
        registerSelect    = sel;
        registerRead      = rd;
        registerAddress   = addr[31:2];
        registerWriteData = wdata;
    endtask

    task automatic wait_ack(input string tag, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (registerAck) break;
        end
        check({tag, "_ack_seen"}, registerAck, 1);
    endtask

    task automatic deselect_and_idle();
        registerSelect = 1'b0;
        tick();
        check("ack_single_cycle", registerAck, 0);
        tick();
    endtask

    task automatic internal_access(input string tag, input logic [31:0] addr, input logic rd,
                                   input logic [31:0] wdata, input logic dec,
                                   input logic [31:0] rdat, input exp_t e);
        int cyc;
        sb.push_back(e);
        decodeInternal   = dec;
        readDataInternal = rdat;
        memReqTrigger    = '0;
        drive_bus(1'b1, rd, addr, wdata);
        wait_ack(tag, cyc);
        check({tag, "_latency"}, cyc, 2);
        deselect_and_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_data"}, registerReadData, 0);
        check({tag, "_ack"}, registerAck, 0);
        check({tag, "_error"}, registerError, 0);
        check({tag, "_decode_en"}, decodeEn, 0);
        check({tag, "_decode_addr"}, decodeAddress, 0);
        check({tag, "_read_s"}, registerReadS, 0);
        check({tag, "_wdata_s"}, registerWriteDataS, 0);
        check({tag, "_mem_channel"}, memChannel, 0);
        check({tag, "_mem_abort"}, memAbort, 0);
        check({tag, "_timeout_flag"}, timeoutFlag, 0);
        check({tag, "_error_count"}, errorCount, 0);
        check({tag, "_last_err_addr"}, lastErrAddr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
        readDataInternal = '0;
        decodeInternal   = 1'b0;
        memReqTrigger    = '0;
        memAckTrigger    = '0;

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Internal hit and internal miss.
        internal_access("hit", 32'h10, 1'b1, 32'h0, 1'b1, 32'hA5A5_0001,
                        mk_ack(32'hA5A5_0001, 1'b0, 32'h10, 2'd0, 32'h0, 1'b0));
        internal_access("miss", 32'h7FC, 1'b1, 32'h0, 1'b0, 32'hDEAD_0002,
                        mk_ack(32'hDEAD_0002, 1'b1, 32'h7FC, 2'd1, 32'h7FC, 1'b0));

        // Deferred access on the lowest requesting channel; other-channel ack ignored.
        sb.push_back(mk_ack(32'h1234, 1'b0, 32'h20, 2'd1, 32'h7FC, 1'b0));
        decodeInternal   = 1'b1;
        readDataInternal = 32'h1234;
        memReqTrigger    = 2'b11;
        drive_bus(1'b1, 1'b1, 32'h20, 32'h0);
        tick();
        tick();
        check("def_channel", memChannel, 2'b01);
        check("def_decode_en", decodeEn, 1);
        memReqTrigger = '0;
        memAckTrigger = 2'b10;
        tick();
        check("def_other_ack_ignored", {registerAck, memChannel}, 3'b001);
        memAckTrigger = '0;
        repeat (3) tick();
        memAckTrigger = 2'b01;
        tick();
        memAckTrigger = '0;
        check("def_ack_not_yet", registerAck, 0);
        tick();
        check("def_ack_pulse", registerAck, 1);
        check("def_channel_cleared", memChannel, 0);
        deselect_and_idle();

        // Timeout: no channel ack, forced errored completion with zero data.
        sb.push_back(mk_ack(32'h0, 1'b1, 32'h40, 2'd2, 32'h40, 1'b1));
        decodeInternal   = 1'b1;
        readDataInternal = 32'h5555_AAAA;
        memReqTrigger    = 2'b01;
        drive_bus(1'b1, 1'b1, 32'h40, 32'h0);
        tick();
        tick();
        memReqTrigger = '0;
        check("to_channel", memChannel, 2'b01);
        wait_ack("to", cyc);
        check("to_latency_from_req", cyc, 9);
        check("to_flag_set", timeoutFlag, 1);
        deselect_and_idle();
        check("to_flag_sticky", timeoutFlag, 1);

        // Clean access clears the sticky timeout flag.
        internal_access("clean", 32'h44, 1'b1, 32'h0, 1'b1, 32'h0BAD_F00D,
                        mk_ack(32'h0BAD_F00D, 1'b0, 32'h44, 2'd2, 32'h40, 1'b0));
        check("to_flag_cleared", timeoutFlag, 0);

        // Abort: deselect seen in REQ together with a channel ack.
        decodeInternal = 1'b1;
        memReqTrigger  = 2'b10;
        drive_bus(1'b1, 1'b1, 32'h80, 32'h0);
        tick();
        tick();
        check("abort_channel", memChannel, 2'b10);
        memReqTrigger = '0;
        sb.push_back(mk_abort());
        registerSelect = 1'b0;
        tick();
        memAckTrigger = 2'b10;
        tick();
        memAckTrigger = '0;
        check("abort_pulse", memAbort, 1);
        check("abort_no_ack", registerAck, 0);
        check("abort_channel_cleared", memChannel, 0);
        check("abort_decode_off", decodeEn, 0);
        tick();
        check("abort_single_cycle", memAbort, 0);
        check("abort_still_no_ack", registerAck, 0);

        // Error counter saturation with write misses (five errored accesses in total).
        internal_access("sat1", 32'h100, 1'b0, 32'h1111_1111, 1'b0, 32'h1,
                        mk_ack(32'h1, 1'b1, 32'h100, 2'd3, 32'h100, 1'b0));
        internal_access("sat2", 32'h104, 1'b0, 32'h2222_2222, 1'b0, 32'h2,
                        mk_ack(32'h2, 1'b1, 32'h104, 2'd3, 32'h104, 1'b0));
        internal_access("sat3", 32'h108, 1'b0, 32'h3333_3333, 1'b0, 32'h3,
                        mk_ack(32'h3, 1'b1, 32'h108, 2'd3, 32'h108, 1'b0));

        // Reset in the middle of a deferred access.
        memReqTrigger = 2'b01;
        drive_bus(1'b1, 1'b1, 32'h200, 32'h0);
        tick();
        tick();
        check("rst_mid_channel", memChannel, 2'b01);
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        registerSelect = 1'b0;
        memReqTrigger  = '0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("rst_no_late_ack", registerAck, 0);

        // Write access after reset completes normally.
        internal_access("post_rst", 32'h300, 1'b0, 32'hCAFE_BABE, 1'b1, 32'h77,
                        mk_ack(32'h77, 1'b0, 32'h300, 2'd0, 32'h0, 1'b0));
        check("post_rst_wdata_s", registerWriteDataS, 32'hCAFE_BABE);
        check("post_rst_read_s", registerReadS, 0);

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
